// File: rtl/pwm_multi_out_pkg.sv
// Shared constants for the multi-channel PWM output selector.
package pwm_multi_out_pkg;

  // Register word addresses
  localparam int unsigned ADDR_MODE     = 0;
  localparam int unsigned ADDR_CTRL     = 1;
  localparam int unsigned ADDR_PRESCALE = 2;
  localparam int unsigned ADDR_STATUS   = 3;
  localparam int unsigned ADDR_DUTY0    = 4;

  // CTRL bit positions
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_RESTART = 1;

  // Prescaler width and STATUS layout
  localparam int unsigned PS_BITS       = 16;
  localparam int unsigned STATUS_EN_BIT = 16;

endpackage

// File: rtl/pwm_multi_out_if.sv
// Peripheral bus slice seen by the PWM block: write strobe, address, data in and read data.
interface pwm_multi_out_if #(
  parameter int unsigned ADDR_BITS = 4
);
  logic                 WE;
  logic [ADDR_BITS-1:0] A;
  logic [31:0]          WD;
  logic [31:0]          RD;

  modport master (output WE, A, WD, input RD);
  modport slave  (input WE, A, WD, output RD);
endinterface

// File: rtl/pwm_multi_out_timebase.sv
// Shared timebase: prescaler producing ticks and the period counter they advance.
module pwm_timebase
  import pwm_multi_out_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_i,
  input  logic                restart_i,
  input  logic [PS_BITS-1:0]  prescale_i,
  output logic [PWM_BITS-1:0] pwm_cnt_o,
  output logic                wrap_c_o
);

  logic [PS_BITS-1:0]  ps_cnt_q, ps_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                tick_c;

  // Next counter values; restart wins over any tick in the same cycle
  always_comb begin
    ps_cnt_d  = ps_cnt_q;
    pwm_cnt_d = pwm_cnt_q;
    tick_c    = en_i && (ps_cnt_q == prescale_i);
    if (restart_i) begin
      ps_cnt_d  = '0;
      pwm_cnt_d = '0;
    end else if (tick_c) begin
      ps_cnt_d  = '0;
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    end else if (en_i) begin
      ps_cnt_d  = ps_cnt_q + PS_BITS'(1);
    end
  end

  // Counter state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_cnt_q  <= '0;
      pwm_cnt_q <= '0;
    end else begin
      ps_cnt_q  <= ps_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign pwm_cnt_o = pwm_cnt_q;
  assign wrap_c_o  = tick_c && (pwm_cnt_q == '1);

endmodule

// File: rtl/pwm_multi_out.sv
// N-channel PWM with shadowed duties and a per-pin select between GPIO value and PWM.
module pwm_multi_out
  import pwm_multi_out_pkg::*;
#(
  parameter int unsigned N_OUTPUTS = 20,
  parameter int unsigned N_PWM     = 4,
  parameter int unsigned PWM_BITS  = 8,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  pwm_multi_out_if.slave       bus,
  input  logic [N_OUTPUTS-1:0] DOUT,
  output logic [15:0]          led,
  output logic [N_OUTPUTS-17:0] opin
);

  logic [N_OUTPUTS-1:0] mode_q, mode_d;
  logic                 en_q, en_d;
  logic [PS_BITS-1:0]   prescale_q, prescale_d;
  logic [PWM_BITS-1:0]  pending_q [N_PWM];
  logic [PWM_BITS-1:0]  pending_d [N_PWM];
  logic [PWM_BITS-1:0]  active_q  [N_PWM];
  logic [PWM_BITS-1:0]  active_d  [N_PWM];
  logic [N_OUTPUTS-1:0] out_q, out_d;
  logic                 restart_c;
  logic                 wrap_c;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic [N_PWM-1:0]     pwm_c;
  logic [31:0]          rd_c;
  logic                 wd_unused_c;

  assign wd_unused_c = ^bus.WD;

  pwm_timebase #(.PWM_BITS(PWM_BITS)) u_timebase (
    .clk        (clk),
    .reset      (reset),
    .en_i       (en_q),
    .restart_i  (restart_c),
    .prescale_i (prescale_q),
    .pwm_cnt_o  (pwm_cnt),
    .wrap_c_o   (wrap_c)
  );

  // Register write decode; oversized write data is truncated to each field
  always_comb begin
    mode_d     = mode_q;
    en_d       = en_q;
    prescale_d = prescale_q;
    pending_d  = pending_q;
    restart_c  = 1'b0;
    if (bus.WE) begin
      if (bus.A == ADDR_BITS'(ADDR_MODE)) mode_d = bus.WD[N_OUTPUTS-1:0];
      if (bus.A == ADDR_BITS'(ADDR_CTRL)) begin
        en_d      = bus.WD[CTRL_EN];
        restart_c = bus.WD[CTRL_RESTART];
      end
      if (bus.A == ADDR_BITS'(ADDR_PRESCALE)) prescale_d = bus.WD[PS_BITS-1:0];
      for (int k = 0; k < int'(N_PWM); k++) begin
        if (bus.A == ADDR_BITS'(ADDR_DUTY0 + k)) pending_d[k] = bus.WD[PWM_BITS-1:0];
      end
    end
  end

  // Active duty follows pending at period end, on restart, or continuously while stopped
  always_comb begin
    active_d = active_q;
    if (restart_c || !en_q || wrap_c) active_d = pending_q;
  end

  // Channel compare and per-pin source select
  always_comb begin
    pwm_c = '0;
    out_d = '0;
    for (int k = 0; k < int'(N_PWM); k++) pwm_c[k] = (pwm_cnt < active_q[k]);
    for (int i = 0; i < int'(N_OUTPUTS); i++) out_d[i] = mode_q[i] ? pwm_c[i % int'(N_PWM)] : DOUT[i];
  end

  // Configuration, duty and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= '0;
      en_q       <= 1'b0;
      prescale_q <= '0;
      out_q      <= '0;
      for (int k = 0; k < int'(N_PWM); k++) begin
        pending_q[k] <= '0;
        active_q[k]  <= '0;
      end
    end else begin
      mode_q     <= mode_d;
      en_q       <= en_d;
      prescale_q <= prescale_d;
      out_q      <= out_d;
      pending_q  <= pending_d;
      active_q   <= active_d;
    end
  end

  // Combinational readback; RESTART is a strobe and never reads back
  always_comb begin
    rd_c = '0;
    if (bus.A == ADDR_BITS'(ADDR_MODE))     rd_c = 32'(mode_q);
    if (bus.A == ADDR_BITS'(ADDR_CTRL))     rd_c[CTRL_EN] = en_q;
    if (bus.A == ADDR_BITS'(ADDR_PRESCALE)) rd_c = 32'(prescale_q);
    if (bus.A == ADDR_BITS'(ADDR_STATUS)) begin
      rd_c[PWM_BITS-1:0]  = pwm_cnt;
      rd_c[STATUS_EN_BIT] = en_q;
    end
    for (int k = 0; k < int'(N_PWM); k++) begin
      if (bus.A == ADDR_BITS'(ADDR_DUTY0 + k)) rd_c = 32'(pending_q[k]);
    end
  end

  assign bus.RD = rd_c;
  assign led    = out_q[15:0];
  assign opin   = out_q[N_OUTPUTS-1:16];

endmodule

// File: tb/tb_pwm_multi_out.sv
// Scoreboard bench for pwm_multi_out: a behavioural model predicts pins and readback.
module tb_pwm_multi_out;

  localparam int unsigned NO = 20;
  localparam int unsigned NP = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NO-1:0] DOUT = '0;
  logic [15:0]   led;
  logic [NO-17:0] opin;

  pwm_multi_out_if #(.ADDR_BITS(4)) bus ();

  pwm_multi_out #(.N_OUTPUTS(NO), .N_PWM(NP), .PWM_BITS(8), .ADDR_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .DOUT  (DOUT),
    .led   (led),
    .opin  (opin)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int hi0   = 0;
  int hi1   = 0;

  logic [31:0] pin_q [$];
  logic [31:0] rd_q  [$];

  // Reference model state
  logic [NO-1:0] m_mode;
  bit            m_en;
  int            m_ps, m_pre, m_cnt;
  int            m_pend [NP];
  int            m_act  [NP];
  logic [NO-1:0] dout_v = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mode = '0; m_en = 1'b0; m_ps = 0; m_pre = 0; m_cnt = 0;
    for (int k = 0; k < NP; k++) begin m_pend[k] = 0; m_act[k] = 0; end
  endtask

  task automatic load_active();
    for (int k = 0; k < NP; k++) m_act[k] = m_pend[k];
  endtask

  // Pin levels the DUT should show after the coming edge
  function automatic logic [31:0] exp_pins(input logic [NO-1:0] d);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NO; i++) r[i] = m_mode[i] ? (m_cnt < m_act[i % NP]) : d[i];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input int a);
    case (a)
      0:          return 32'(m_mode);
      1:          return 32'(m_en);
      2:          return 32'(m_pre);
      3:          return (32'(m_en) << 16) | 32'(m_cnt);
      4, 5, 6, 7: return 32'(m_pend[a-4]);
      default:    return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock edge
  task automatic m_step(input bit we, input int a, input logic [31:0] wd);
    bit rs, tick, wrap;
    rs   = we && (a == 1) && wd[1];
    tick = m_en && (m_ps == m_pre);
    wrap = tick && (m_cnt == 255);
    if (rs) begin
      m_ps = 0; m_cnt = 0; load_active();
    end else if (m_en) begin
      if (tick) begin m_ps = 0; m_cnt = (m_cnt + 1) % 256; end
      else m_ps = (m_ps + 1) % 65536;
      if (wrap) load_active();
    end else begin
      load_active();
    end
    if (we) begin
      case (a)
        0:          m_mode = wd[NO-1:0];
        1:          m_en = wd[0];
        2:          m_pre = int'(wd[15:0]);
        4, 5, 6, 7: m_pend[a-4] = int'(wd[7:0]);
        default: ;
      endcase
    end
  endtask

  // One bus cycle: drive, predict, step the model
  task automatic cyc(input bit we, input int a, input logic [31:0] wd);
    @(negedge clk);
    bus.WE = we; bus.A = 4'(a); bus.WD = wd; DOUT = dout_v;
    pin_q.push_back(exp_pins(dout_v));
    if (!we) rd_q.push_back(exp_rd(a));
    m_step(we, a, wd);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc(1'b0, int'($urandom_range(0, 15)), 32'd0);
  endtask

  // Stop, load prescale/duties/mode, then restart with EN=1
  task automatic cfg(input int pre, input int d0, input int d1, input int d2, input int d3,
                     input logic [NO-1:0] mode);
    cyc(1'b1, 1, 32'd0);
    cyc(1'b1, 2, 32'(pre));
    cyc(1'b1, 4, 32'(d0) | 32'hFFFF_FF00);
    cyc(1'b1, 5, 32'(d1));
    cyc(1'b1, 6, 32'(d2));
    cyc(1'b1, 7, 32'(d3));
    cyc(1'b1, 0, 32'(mode));
    cyc(1'b1, 1, 32'd3);
  endtask

  // Count high cycles on led[0]/led[1] over n consecutive outputs
  task automatic measure(input int n, output int h0, output int h1);
    @(posedge clk); #2;
    hi0 = 0; hi1 = 0;
    idle(n);
    @(posedge clk); #2;
    h0 = hi0; h1 = hi1;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    reset = 1'b1;
    #1 check("reset_pins", {12'd0, opin, led}, 32'd0);
    pin_q.delete(); rd_q.delete();
    m_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Pin monitor
  always @(posedge clk) begin
    #1;
    if (led[0] === 1'b1) hi0++;
    if (led[1] === 1'b1) hi1++;
    if (pin_q.size() > 0) check("pins", {12'd0, opin, led}, pin_q.pop_front());
  end

  // Readback monitor
  always @(negedge clk) begin
    #1;
    if (rd_q.size() > 0) check("rd", bus.RD, rd_q.pop_front());
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int h0, h1;
    bus.WE = 1'b0; bus.A = '0; bus.WD = '0;
    m_reset();
    #1 check("reset_init_pins", {12'd0, opin, led}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Every address reads zero out of reset, then GPIO passthrough
    for (int a = 0; a < 16; a++) cyc(1'b0, a, 32'd0);
    dout_v = 20'hFFFFF;
    idle(3);
    dout_v = 20'h5A5A5;
    idle(3);

    // Duty 64 / 0 / 255 at full rate
    cfg(0, 64, 0, 0, 0, 20'h1);
    measure(256, h0, h1); check("duty64_high", 32'(h0), 32'd64);
    cfg(0, 0, 0, 0, 0, 20'h1);
    measure(256, h0, h1); check("duty0_high", 32'(h0), 32'd0);
    cfg(0, 255, 0, 0, 0, 20'h1);
    measure(256, h0, h1); check("duty255_high", 32'(h0), 32'd255);

    // Reset while pins toggle
    cfg(0, 128, 0, 0, 0, 20'h1);
    idle(140);
    do_reset();
    for (int a = 0; a < 16; a++) cyc(1'b0, a, 32'd0);

    // Prescale 3: 1024-clock period, half high on channel 1
    cfg(3, 0, 128, 0, 0, 20'h2);
    for (int j = 0; j < 12; j++) cyc(1'b0, 3, 32'd0);
    measure(1024, h0, h1); check("ps3_ch1_high", 32'(h1), 32'd512);

    // Mid-period duty update and a write landing on the wrap cycle
    cfg(0, 64, 0, 0, 0, 20'h1);
    idle(100);
    cyc(1'b1, 4, 32'd200);
    idle(154);
    cyc(1'b1, 4, 32'd50);
    idle(520);

    // Restart coinciding with wrap; EN=0 freezes the counter and applies duty at once
    cfg(0, 10, 20, 30, 40, 20'hFFFFF);
    idle(255);
    cyc(1'b1, 1, 32'd3);
    cyc(1'b0, 1, 32'd0);
    cyc(1'b0, 3, 32'd0);
    idle(30);
    cyc(1'b1, 1, 32'd0);
    for (int j = 0; j < 4; j++) cyc(1'b0, 3, 32'd0);
    cyc(1'b1, 4, 32'd5);
    idle(8);

    // Channel mapping across all pins, plus unmapped read
    cfg(0, 32, 64, 96, 128, 20'hFFFFF);
    for (int j = 0; j < 300; j++) begin dout_v = 20'($urandom); idle(1); end
    cyc(1'b0, 12, 32'd0);

    // Randomised phases
    for (int p = 0; p < 6; p++) begin
      cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 20'($urandom));
      for (int j = 0; j < 600; j++) begin
        int r;
        r = int'($urandom_range(0, 15));
        dout_v = 20'($urandom);
        if (r == 0)      cyc(1'b1, 4 + int'($urandom_range(0, 3)), $urandom);
        else if (r == 1) cyc(1'b1, 0, $urandom);
        else if (r == 2) cyc(1'b1, 1, 32'($urandom_range(0, 3)));
        else             idle(1);
      end
    end

    repeat (3) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
